timing_loop_ctrl: RTL

Symbol-timing loop controller for the QPSK demodulator. Consumes NCO strobes and interpolator outputs, classifies each strobe as a mid-symbol or on-symbol sample, computes the Gardner timing error once per symbol, and runs a PI loop filter. Drives the NCO control word `wn` and emits one decimated symbol per symbol period to the downstream decision logic.

---
 rtl/qpsk_timing_pkg.sv | 50 +++++
 rtl/gardner_ted.sv | 74 +++++++
 rtl/timing_loop_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/qpsk_timing_pkg.sv
// Shared types, widths, loop constants and arithmetic helpers for the QPSK
// symbol-timing loop (timing_loop_ctrl and gardner_ted).
package qpsk_timing_pkg;

  localparam int SAMP_W = 16;
  localparam int ERR_W  = 16;
  localparam int WN_W   = 16;
  localparam int DIFF_W = 17;
  localparam int PROD_W = 33;
  localparam int SUM_W  = 34;
  localparam int FILT_W = 18;

  localparam int ERR_SHIFT = 14;
  localparam int KP_SHIFT  = 4;
  localparam int KI_SHIFT  = 8;

  localparam logic [WN_W-1:0] WN_NOM   = 16'h4000;
  localparam logic [WN_W-1:0] WN_MIN   = 16'h3000;
  localparam logic [WN_W-1:0] WN_MAX   = 16'h5000;
  localparam logic [15:0]     INT_LIM  = 16'h0800;
  localparam logic [15:0]     LOCK_THR = 16'd64;
  localparam logic [7:0]      LOCK_CNT = 8'd32;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_MID  = 2'd1,
    S_SYM  = 2'd2
  } phase_t;

  function automatic logic signed [ERR_W-1:0] sat16(input logic signed [SUM_W-1:0] x);
    if (x > 34'sd32767)
      sat16 = 16'sh7fff;
    else if (x < -34'sd32768)
      sat16 = 16'sh8000;
    else
      sat16 = x[ERR_W-1:0];
  endfunction

  function automatic logic signed [FILT_W-1:0] clamp18(input logic signed [FILT_W-1:0] x,
                                                       input logic signed [FILT_W-1:0] lo,
                                                       input logic signed [FILT_W-1:0] hi);
    if (x > hi)
      clamp18 = hi;
    else if (x < lo)
      clamp18 = lo;
    else
      clamp18 = x;
  endfunction

endpackage

// File: rtl/gardner_ted.sv
// Three-stage Gardner timing error pipeline: differences, products, then
// sum / arithmetic shift / saturate. Initiation interval of one.
module gardner_ted
  import qpsk_timing_pkg::*;
#(
  parameter int SHIFT = ERR_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic signed [SAMP_W-1:0] i_prev_i,
  input  logic signed [SAMP_W-1:0] i_prev_q,
  input  logic signed [SAMP_W-1:0] i_mid_i,
  input  logic signed [SAMP_W-1:0] i_mid_q,
  input  logic signed [SAMP_W-1:0] i_cur_i,
  input  logic signed [SAMP_W-1:0] i_cur_q,
  output logic                     o_valid,
  output logic signed [ERR_W-1:0]  o_err
);

  logic                     r_v1, r_v2, r_v3;
  logic signed [DIFF_W-1:0] r_d_i, r_d_q;
  logic signed [SAMP_W-1:0] r_m_i, r_m_q;
  logic signed [PROD_W-1:0] r_p_i, r_p_q;
  logic signed [ERR_W-1:0]  r_err;

  logic signed [DIFF_W-1:0] w_prev_i_x, w_prev_q_x, w_cur_i_x, w_cur_q_x;
  logic signed [PROD_W-1:0] w_m_i_x, w_m_q_x, w_d_i_x, w_d_q_x;
  logic signed [SUM_W-1:0]  w_p_i_x, w_p_q_x, w_sum, w_shift;

  // Operands are sign-extended to the result width before each operation.
  assign w_prev_i_x = i_prev_i;
  assign w_prev_q_x = i_prev_q;
  assign w_cur_i_x  = i_cur_i;
  assign w_cur_q_x  = i_cur_q;
  assign w_m_i_x    = r_m_i;
  assign w_m_q_x    = r_m_q;
  assign w_d_i_x    = r_d_i;
  assign w_d_q_x    = r_d_q;
  assign w_p_i_x    = r_p_i;
  assign w_p_q_x    = r_p_q;
  assign w_sum      = w_p_i_x + w_p_q_x;
  assign w_shift    = w_sum >>> SHIFT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_d_i <= '0;
      r_d_q <= '0;
      r_m_i <= '0;
      r_m_q <= '0;
      r_p_i <= '0;
      r_p_q <= '0;
      r_err <= '0;
    end else begin
      r_v1  <= i_valid;
      r_d_i <= w_prev_i_x - w_cur_i_x;
      r_d_q <= w_prev_q_x - w_cur_q_x;
      r_m_i <= i_mid_i;
      r_m_q <= i_mid_q;
      r_v2  <= r_v1;
      r_p_i <= w_m_i_x * w_d_i_x;
      r_p_q <= w_m_q_x * w_d_q_x;
      r_v3  <= r_v2;
      r_err <= sat16(w_shift);
    end
  end

  assign o_valid = r_v3;
  assign o_err   = r_err;

endmodule

// File: rtl/timing_loop_ctrl.sv
// Symbol-timing loop: strobe phase FSM, Gardner error, PI loop filter driving wn.
// Optional lock detector enabled by defining TIMING_LOCK_DET_EN.
module timing_loop_ctrl
  import qpsk_timing_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              loop_en,
  input  logic              strobe,
  input  logic [SAMP_W-1:0] interp_i,
  input  logic [SAMP_W-1:0] interp_q,
  output logic [WN_W-1:0]   wn,
  output logic              sym_valid,
  output logic [SAMP_W-1:0] sym_i,
  output logic [SAMP_W-1:0] sym_q,
  output logic              locked,
  output logic [1:0]        o_dbg_state,
  output logic [15:0]       o_dbg_integ
);

  // strobe is a qualifier, not a handshake: every strobe cycle carries a valid
  // sample and is always consumed; sym_valid is a one-cycle pulse with no ready.
  localparam logic signed [FILT_W-1:0] C_INT_HI = {2'b00, INT_LIM};
  localparam logic signed [FILT_W-1:0] C_INT_LO = -C_INT_HI;
  localparam logic signed [FILT_W-1:0] C_WN_NOM = {2'b00, WN_NOM};
  localparam logic signed [FILT_W-1:0] C_WN_MIN = {2'b00, WN_MIN};
  localparam logic signed [FILT_W-1:0] C_WN_MAX = {2'b00, WN_MAX};

  phase_t                   r_state;
  logic signed [SAMP_W-1:0] r_prev_i, r_prev_q, r_mid_i, r_mid_q;
  logic                     r_sym_valid;
  logic [SAMP_W-1:0]        r_sym_i, r_sym_q;
  logic signed [15:0]       r_integ;
  logic [WN_W-1:0]          r_wn;

  logic                     w_ted_fire;
  logic                     w_err_vld;
  logic signed [ERR_W-1:0]  w_err;
  logic signed [FILT_W-1:0] w_e18, w_e_kp, w_e_ki, w_integ18, w_integ_new, w_wn18, w_wn_new;

  assign w_ted_fire = strobe && (r_state == S_SYM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT;
      r_prev_i    <= '0;
      r_prev_q    <= '0;
      r_mid_i     <= '0;
      r_mid_q     <= '0;
      r_sym_valid <= 1'b0;
      r_sym_i     <= '0;
      r_sym_q     <= '0;
    end else begin
      r_sym_valid <= 1'b0;
      if (strobe) begin
        case (r_state)
          S_INIT, S_SYM: begin
            r_prev_i    <= interp_i;
            r_prev_q    <= interp_q;
            r_sym_valid <= 1'b1;
            r_sym_i     <= interp_i;
            r_sym_q     <= interp_q;
            r_state     <= S_MID;
          end
          S_MID: begin
            r_mid_i <= interp_i;
            r_mid_q <= interp_q;
            r_state <= S_SYM;
          end
          default: r_state <= S_INIT;
        endcase
      end
    end
  end

  gardner_ted #(
    .SHIFT(ERR_SHIFT)
  ) u_ted (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_ted_fire),
    .i_prev_i (r_prev_i),
    .i_prev_q (r_prev_q),
    .i_mid_i  (r_mid_i),
    .i_mid_q  (r_mid_q),
    .i_cur_i  (interp_i),
    .i_cur_q  (interp_q),
    .o_valid  (w_err_vld),
    .o_err    (w_err)
  );

  always_comb begin
    w_e18       = {{2{w_err[ERR_W-1]}}, w_err};
    w_e_kp      = w_e18 >>> KP_SHIFT;
    w_e_ki      = w_e18 >>> KI_SHIFT;
    w_integ18   = {{2{r_integ[15]}}, r_integ} + w_e_ki;
    w_integ_new = clamp18(w_integ18, C_INT_LO, C_INT_HI);
    w_wn18      = C_WN_NOM + w_e_kp + w_integ_new;
    w_wn_new    = clamp18(w_wn18, C_WN_MIN, C_WN_MAX);
  end

  // An open loop overrides any filter update arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || !loop_en) begin
      r_integ <= '0;
      r_wn    <= WN_NOM;
    end else if (w_err_vld) begin
      r_integ <= w_integ_new[15:0];
      r_wn    <= w_wn_new[WN_W-1:0];
    end
  end

`ifdef TIMING_LOCK_DET_EN
  logic [7:0]         r_lock_cnt;
  logic               r_locked;
  logic signed [16:0] w_e17;
  logic [16:0]        w_abs_e;

  assign w_e17   = w_err;
  assign w_abs_e = w_e17[16] ? 17'(-w_e17) : 17'(w_e17);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (w_err_vld) begin
      if (w_abs_e < {1'b0, LOCK_THR}) begin
        if (r_lock_cnt != LOCK_CNT)
          r_lock_cnt <= r_lock_cnt + 8'd1;
        if (r_lock_cnt >= LOCK_CNT - 8'd1)
          r_locked <= 1'b1;
      end else begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end
    end
  end

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

  assign wn          = r_wn;
  assign sym_valid   = r_sym_valid;
  assign sym_i       = r_sym_i;
  assign sym_q       = r_sym_q;
  assign o_dbg_state = r_state;
  assign o_dbg_integ = r_integ;

endmodule
